carry_resolver_stream: RTL and testbench

Parametrised carry-resolution stage for the arithmetic-encoder output path. It accepts beats of up to LANES raw bytes per handshake; each byte carries a carry-out bit toward the byte before it. It holds one pending byte plus a run of 0xFF bytes, resolves carries into them, and emits compressed records of the form {head byte, run byte, run length} over a valid/ready interface. It sits between the arithmetic stage (bitstream generation) and the byte serialiser. It generalises the fixed 2-input, flag-coded carry stage with lane count, run-counter width, backpressure, explicit flush and error reporting.

---
 rtl/carry_resolver_stream.sv | 195 +++++++++++++++++++
 tb/tb_carry_resolver_stream.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_resolver_stream.sv
// carry_resolver_stream
//   Carry-resolution stage between the arithmetic encoder and the byte
//   serialiser. It holds one pending byte plus a run of 0xFF bytes. Carries
//   arriving on later bytes are resolved into that pending group. The stage
//   then emits compressed records {head, run byte, run length}.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   S_EMPTY  | no pending byte; the next lane starts a stream
//   S_HOLD   | pending byte (and possibly a 0xFF run) held
//   S_SERIAL | lanes 1..count-1 of the captured beat still to process
//   S_FLUSH  | emit the final record of the stream
//
// Ports
//   cr_clk, cr_reset            clock, async active-high reset
//   in_valid/in_ready           input beat handshake
//   in_count                    valid lanes in beat (0 only with in_final)
//   in_bytes                    packed lanes {carry, byte}, lane 0 in LSBs
//   in_final                    flush after this beat
//   out_valid/out_ready         record handshake
//   out_head, out_head_vld      head byte, present unless empty flush
//   out_run_byte, out_run_len   run byte (0xFF or 0x00) and its repeat count
//   out_last                    final record of a stream
//   out_error                   sticky protocol/overflow error
module carry_resolver_stream #(
    parameter int BITSTREAM_WIDTH = 8,
    parameter int LANES           = 2,
    parameter int RUN_WIDTH       = 8,
    parameter int CNT_WIDTH       = $clog2(LANES + 1)
) (
    input  logic                                 cr_clk,
    input  logic                                 cr_reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [CNT_WIDTH-1:0]                 in_count,
    input  logic [LANES*(BITSTREAM_WIDTH+1)-1:0] in_bytes,
    input  logic                                 in_final,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [BITSTREAM_WIDTH-1:0]           out_head,
    output logic                                 out_head_vld,
    output logic [BITSTREAM_WIDTH-1:0]           out_run_byte,
    output logic [RUN_WIDTH-1:0]                 out_run_len,
    output logic                                 out_last,
    output logic                                 out_error
);

    localparam int LW = BITSTREAM_WIDTH + 1;
    localparam logic [BITSTREAM_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [RUN_WIDTH-1:0]       RUN_MAX  = '1;

    typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_SERIAL, S_FLUSH} state_t;

    state_t                       state;
    logic [BITSTREAM_WIDTH-1:0]   pend;
    logic                         pend_vld;
    logic [RUN_WIDTH-1:0]         run;
    logic [LANES*LW-1:0]          beat_q;
    logic [CNT_WIDTH-1:0]         beat_cnt;
    logic [CNT_WIDTH-1:0]         lane_idx;
    logic                         beat_final;

    logic [LW-1:0]                lane;
    logic                         lane_c;
    logic [BITSTREAM_WIDTH-1:0]   lane_v;
    logic                         out_free;
    logic                         accept;
    logic                         step_fire;
    logic                         step_emit;
    logic                         step_err;
    logic                         flush_fire;
    logic [BITSTREAM_WIDTH-1:0]   step_pend;
    logic [RUN_WIDTH-1:0]         step_run;

    assign out_free = !out_valid || out_ready;
    assign in_ready = ((state == S_EMPTY) || (state == S_HOLD)) && out_free && !cr_reset;
    assign accept   = in_valid && in_ready;

    // One lane is resolved per cycle: lane 0 straight from the input on the
    // accept edge, later lanes from the captured beat.
    always_comb begin
        lane = in_bytes[LW-1:0];
        if (state == S_SERIAL) begin
            lane = beat_q[lane_idx*LW +: LW];
        end
        lane_c = lane[LW-1];
        lane_v = lane[BITSTREAM_WIDTH-1:0];

        step_emit = pend_vld && (lane_c || (lane_v != ALL_ONES));
        step_err  = (!pend_vld && lane_c)
                 || (pend_vld && lane_c && (pend == ALL_ONES))
                 || (pend_vld && !lane_c && (lane_v == ALL_ONES) && (run == RUN_MAX));

        step_pend = pend;
        step_run  = run;
        if (!pend_vld || step_emit) begin
            step_pend = lane_v;
            step_run  = '0;
        end else if (run != RUN_MAX) begin
            step_run = run + 1'b1;
        end

        // A non-emitting serial lane proceeds even while a record is held.
        step_fire  = (accept && (in_count != '0))
                  || ((state == S_SERIAL) && (!step_emit || out_free));
        flush_fire = (state == S_FLUSH) && out_free;
    end

    always_ff @(posedge cr_clk or posedge cr_reset) begin
        if (cr_reset) begin
            state        <= S_EMPTY;
            pend         <= '0;
            pend_vld     <= 1'b0;
            run          <= '0;
            beat_q       <= '0;
            beat_cnt     <= '0;
            lane_idx     <= '0;
            beat_final   <= 1'b0;
            out_valid    <= 1'b0;
            out_head     <= '0;
            out_head_vld <= 1'b0;
            out_run_byte <= '0;
            out_run_len  <= '0;
            out_last     <= 1'b0;
            out_error    <= 1'b0;
        end else begin
            case (state)
                S_EMPTY, S_HOLD: begin
                    if (accept) begin
                        beat_q     <= in_bytes;
                        beat_cnt   <= in_count;
                        beat_final <= in_final;
                        lane_idx   <= CNT_WIDTH'(1);
                        if (in_count == '0) begin
                            if (in_final) begin
                                state <= S_FLUSH;
                            end else begin
                                out_error <= 1'b1;
                            end
                        end else if (in_count > CNT_WIDTH'(1)) begin
                            state <= S_SERIAL;
                        end else begin
                            state <= in_final ? S_FLUSH : S_HOLD;
                        end
                    end
                end
                S_SERIAL: begin
                    if (step_fire) begin
                        if (lane_idx == beat_cnt - 1'b1) begin
                            state <= beat_final ? S_FLUSH : S_HOLD;
                        end else begin
                            lane_idx <= lane_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    if (flush_fire) begin
                        state <= S_EMPTY;
                    end
                end
            endcase

            if (step_fire) begin
                pend     <= step_pend;
                run      <= step_run;
                pend_vld <= 1'b1;
                if (step_err) begin
                    out_error <= 1'b1;
                end
            end

            if (step_fire && step_emit) begin
                out_valid    <= 1'b1;
                out_head     <= lane_c ? pend + 1'b1 : pend;
                out_head_vld <= 1'b1;
                out_run_byte <= lane_c ? '0 : ALL_ONES;
                out_run_len  <= run;
                out_last     <= 1'b0;
            end else if (flush_fire) begin
                out_valid    <= 1'b1;
                out_head     <= pend_vld ? pend : '0;
                out_head_vld <= pend_vld;
                out_run_byte <= pend_vld ? ALL_ONES : '0;
                out_run_len  <= pend_vld ? run : '0;
                out_last     <= 1'b1;
                pend         <= '0;
                pend_vld     <= 1'b0;
                run          <= '0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_carry_resolver_stream.sv
// Testbench for carry_resolver_stream (LANES=4, RUN_WIDTH=3).
// The reference model works on the lane sequence of a stream; it ignores beat
// boundaries and cycle timing. Expected records are queued, and a scoreboard
// pops one record for each output handshake.
module tb_carry_resolver_stream;

    localparam int BW   = 8;
    localparam int NL   = 4;
    localparam int RW   = 3;
    localparam int CW   = $clog2(NL + 1);
    localparam int RMAX = (1 << RW) - 1;

    typedef struct {
        int head;
        int head_vld;
        int run_byte;
        int run_len;
        int last;
    } rec_t;

    logic              cr_clk = 1'b0;
    logic              cr_reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CW-1:0]     in_count = '0;
    logic [NL*9-1:0]   in_bytes = '0;
    logic              in_final = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [BW-1:0]     out_head;
    logic              out_head_vld;
    logic [BW-1:0]     out_run_byte;
    logic [RW-1:0]     out_run_len;
    logic              out_last;
    logic              out_error;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ready_mode = 0;   // 0 always ready, 1 random, 2 held low
    rec_t expq[$];
    logic [8:0] lanes_buf [NL];

    int m_pend = -1;        // -1: no pending byte
    int m_run  = 0;
    int m_err  = 0;

    carry_resolver_stream #(
        .BITSTREAM_WIDTH(BW),
        .LANES(NL),
        .RUN_WIDTH(RW)
    ) dut (
        .cr_clk(cr_clk),
        .cr_reset(cr_reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_count(in_count),
        .in_bytes(in_bytes),
        .in_final(in_final),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_head(out_head),
        .out_head_vld(out_head_vld),
        .out_run_byte(out_run_byte),
        .out_run_len(out_run_len),
        .out_last(out_last),
        .out_error(out_error)
    );

    always #5 cr_clk = ~cr_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_rec(int h, int hv, int rb, int rl, int l);
        rec_t r;
        r.head = h; r.head_vld = hv; r.run_byte = rb; r.run_len = rl; r.last = l;
        expq.push_back(r);
    endfunction

    function automatic void model_lane(logic [8:0] b);
        int c = int'(b[8]);
        int v = int'(b[7:0]);
        if (m_pend < 0) begin
            if (c == 1) m_err = 1;
            m_pend = v; m_run = 0;
        end else if (c == 1) begin
            if (m_pend == 255) m_err = 1;
            push_rec((m_pend + 1) % 256, 1, 0, m_run, 0);
            m_pend = v; m_run = 0;
        end else if (v == 255) begin
            if (m_run == RMAX) m_err = 1;
            else m_run++;
        end else begin
            push_rec(m_pend, 1, 255, m_run, 0);
            m_pend = v; m_run = 0;
        end
    endfunction

    function automatic void model_flush();
        if (m_pend >= 0) push_rec(m_pend, 1, 255, m_run, 1);
        else push_rec(0, 0, 0, 0, 1);
        m_pend = -1; m_run = 0;
    endfunction

    // Scoreboard: out_ready is chosen on the falling edge. A handshake seen
    // here completes on the next rising edge.
    always @(negedge cr_clk) begin
        rec_t r;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
        if (!cr_reset && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("extra_record", 32'(out_valid), 32'(0));
            end else begin
                r = expq.pop_front();
                check("head_vld", 32'(out_head_vld), 32'(r.head_vld));
                check("head", 32'(out_head), 32'(r.head));
                check("run_len", 32'(out_run_len), 32'(r.run_len));
                check("last", 32'(out_last), 32'(r.last));
                if (r.head_vld == 1) check("run_byte", 32'(out_run_byte), 32'(r.run_byte));
            end
        end
    end

    task automatic send_beat(input int n, input bit fin);
        logic [NL*9-1:0] pk = '0;
        bit got = 0;
        for (int i = 0; i < n; i++) pk[i*9 +: 9] = lanes_buf[i];
        for (int i = 0; i < n; i++) model_lane(lanes_buf[i]);
        if (fin) model_flush();
        @(negedge cr_clk); #1;
        in_bytes = pk; in_count = CW'(n); in_final = fin; in_valid = 1'b1;
        for (int t = 0; t < 500 && !got; t++) begin
            if (in_ready) begin
                @(posedge cr_clk);
                got = 1;
            end else begin
                @(negedge cr_clk); #1;
            end
        end
        #1;
        in_valid = 1'b0; in_final = 1'b0;
        if (!got) check("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge cr_clk); #2;
            if (expq.size() == 0 && !out_valid) done = 1;
        end
        if (!done) check("drain_timeout", 32'(0), 32'(1));
    endtask

    task automatic do_reset();
        @(negedge cr_clk);
        cr_reset = 1'b1;
        expq.delete();
        m_pend = -1; m_run = 0; m_err = 0;
        @(negedge cr_clk);
        @(negedge cr_clk);
        cr_reset = 1'b0;
    endtask

    function automatic logic [8:0] rand_lane();
        int r = $urandom_range(0, 9);
        logic [8:0] b;
        if (r < 1)      b = {1'b1, 8'($urandom_range(0, 255))};
        else if (r < 5) b = 9'h0FF;
        else            b = {1'b0, 8'($urandom_range(0, 255))};
        return b;
    endfunction

    initial begin
        // reset state
        #2;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_error", 32'(out_error), 32'(0));
        check("rst_out_head", 32'(out_head), 32'(0));
        do_reset();

        // two lanes in one beat, final
        lanes_buf[0] = 9'h012; lanes_buf[1] = 9'h034;
        send_beat(2, 1);
        wait_drain();
        check("err_t1", 32'(out_error), 32'(0));

        // carry resolves a 0xFF run
        lanes_buf[0] = 9'h040; lanes_buf[1] = 9'h0FF; lanes_buf[2] = 9'h0FF; lanes_buf[3] = 9'h105;
        send_beat(4, 0);
        send_beat(0, 1);
        wait_drain();

        // run without carry, then empty-count flush beat
        lanes_buf[0] = 9'h040; lanes_buf[1] = 9'h0FF; lanes_buf[2] = 9'h0FF; lanes_buf[3] = 9'h0FF;
        send_beat(4, 0);
        lanes_buf[0] = 9'h010;
        send_beat(1, 0);
        send_beat(0, 1);
        wait_drain();
        check("err_t3", 32'(out_error), 32'(0));

        // empty flush record
        send_beat(0, 1);
        wait_drain();

        // backpressure: record held for 5 cycles
        ready_mode = 2;
        lanes_buf[0] = 9'h020; lanes_buf[1] = 9'h030;
        send_beat(2, 0);
        @(negedge cr_clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge cr_clk); #1;
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_head", 32'(out_head), 32'(expq[0].head));
            check("hold_run_len", 32'(out_run_len), 32'(expq[0].run_len));
            check("hold_in_ready", 32'(in_ready), 32'(0));
        end
        ready_mode = 1;
        send_beat(0, 1);
        wait_drain();
        check("err_hold", 32'(out_error), 32'(0));

        // randomized streams
        for (int s = 0; s < 40; s++) begin
            int nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                int n = $urandom_range(1, NL);
                bit fin = (b == nb - 1);
                if (fin && $urandom_range(0, 4) == 0) n = 0;
                for (int i = 0; i < NL; i++) lanes_buf[i] = rand_lane();
                send_beat(n, fin);
            end
            wait_drain();
        end
        check("err_random", 32'(out_error), 32'(m_err));

        // carry into empty
        ready_mode = 0;
        do_reset();
        lanes_buf[0] = 9'h1AA;
        send_beat(1, 1);
        wait_drain();
        check("err_carry_empty", 32'(out_error), 32'(1));

        // run saturation
        do_reset();
        lanes_buf[0] = 9'h040; lanes_buf[1] = 9'h0FF; lanes_buf[2] = 9'h0FF; lanes_buf[3] = 9'h0FF;
        send_beat(4, 0);
        for (int i = 0; i < NL; i++) lanes_buf[i] = 9'h0FF;
        send_beat(4, 0);
        send_beat(2, 1);
        wait_drain();
        check("err_saturate", 32'(out_error), 32'(1));

        // head wrap
        do_reset();
        lanes_buf[0] = 9'h0FF; lanes_buf[1] = 9'h101;
        send_beat(2, 1);
        wait_drain();
        check("err_wrap", 32'(out_error), 32'(1));

        // async reset while a 4-lane beat is stalled in serial processing
        do_reset();
        ready_mode = 2;
        lanes_buf[0] = 9'h011; lanes_buf[1] = 9'h022; lanes_buf[2] = 9'h033; lanes_buf[3] = 9'h044;
        send_beat(4, 0);
        @(negedge cr_clk);
        @(negedge cr_clk);
        check("stall_in_ready", 32'(in_ready), 32'(0));
        #2;
        cr_reset = 1'b1;
        #1;
        check("areset_valid", 32'(out_valid), 32'(0));
        check("areset_head", 32'(out_head), 32'(0));
        check("areset_run_len", 32'(out_run_len), 32'(0));
        check("areset_in_ready", 32'(in_ready), 32'(0));
        expq.delete();
        m_pend = -1; m_run = 0; m_err = 0;
        @(negedge cr_clk);
        cr_reset = 1'b0;
        ready_mode = 1;
        lanes_buf[0] = 9'h155;
        send_beat(1, 1);
        wait_drain();
        check("err_after_reset", 32'(out_error), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
